// File: rtl/fp2int_conv.sv
// fp2int_conv: multi-cycle IEEE-754 single to int32/uint32 converter.
// Bit-serial shifter with round-to-nearest-even; overflow and NaN saturate with invalid.
module fp2int_conv (
   input  logic        clk,
   input  logic        rst,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [31:0] in,
   input  logic        is_signed,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] out,
   output logic        invalid,
   output logic        inexact
);
   typedef enum logic [1:0] {IDLE, SHIFT, ROUND, DONE} state_t;
   state_t      state_q;
   logic        sign_q, sgn_q, left_q, ovf_q, guard_q, sticky_q, invalid_q, inexact_q;
   logic [4:0]  n_q;
   logic [31:0] mag_q, out_q;
   logic [7:0]  e;
   logic [22:0] m;
   logic        ovf_d, nan_d, guard_d, sticky_d, inc, invalid_d, inexact_d;
   logic [4:0]  n_d;
   logic [31:0] mag_d, rmag, out_d;
   always_comb begin
      e = in[30:23];
      m = in[22:0];
      nan_d = e == 8'd255 && m != 23'd0;
      ovf_d = e == 8'd255 || (is_signed ? (e >= 8'd158 && !(in[31] && e == 8'd158 && m == 23'd0))
                                         : e >= 8'd159);
      n_d = ovf_d ? 5'd0 : (e >= 8'd127 && e < 8'd150) ? 5'(8'd150 - e)
                         : (e > 8'd150) ? 5'(e - 8'd150) : 5'd0;
      mag_d = (e >= 8'd127 && !ovf_d) ? {8'd0, 1'b1, m} : 32'd0;
      // values below 1.0 collapse straight into guard/sticky with a zero magnitude
      guard_d = e == 8'd126;
      sticky_d = e == 8'd126 ? m != 23'd0 : e < 8'd126 && (e != 8'd0 || m != 23'd0);
   end
   always_comb begin
      inc = guard_q & (sticky_q | mag_q[0]);
      rmag = mag_q + {31'd0, inc};
      out_d = sign_q && sgn_q ? -rmag : rmag;
      invalid_d = 1'b0;
      inexact_d = guard_q | sticky_q;
      if (ovf_q) begin
         out_d = sgn_q ? (sign_q ? 32'h8000_0000 : 32'h7FFF_FFFF) : (sign_q ? 32'd0 : 32'hFFFF_FFFF);
         invalid_d = 1'b1;
         inexact_d = 1'b0;
      end else if (sign_q && !sgn_q) begin
         out_d = 32'd0;
         invalid_d = rmag != 32'd0;
         inexact_d = rmag == 32'd0 && (guard_q | sticky_q);
      end
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         sign_q <= 1'b0;
         sgn_q <= 1'b0;
         left_q <= 1'b0;
         ovf_q <= 1'b0;
         guard_q <= 1'b0;
         sticky_q <= 1'b0;
         n_q <= 5'd0;
         mag_q <= 32'd0;
         out_q <= 32'd0;
         invalid_q <= 1'b0;
         inexact_q <= 1'b0;
      end else begin
         case (state_q)
            IDLE: if (in_valid) begin
               sign_q <= in[31] & ~nan_d;
               sgn_q <= is_signed;
               left_q <= e > 8'd150;
               ovf_q <= ovf_d;
               guard_q <= guard_d;
               sticky_q <= sticky_d;
               n_q <= n_d;
               mag_q <= mag_d;
               state_q <= n_d != 5'd0 ? SHIFT : ROUND;
            end
            SHIFT: begin
               mag_q <= left_q ? mag_q << 1 : mag_q >> 1;
               guard_q <= left_q ? guard_q : mag_q[0];
               sticky_q <= left_q ? sticky_q : sticky_q | guard_q;
               n_q <= n_q - 5'd1;
               state_q <= n_q == 5'd1 ? ROUND : SHIFT;
            end
            ROUND: begin
               out_q <= out_d;
               invalid_q <= invalid_d;
               inexact_q <= inexact_d;
               state_q <= DONE;
            end
            DONE: state_q <= out_ready ? IDLE : DONE;
            default: state_q <= IDLE;
         endcase
      end
   end
   assign in_ready = state_q == IDLE;
   assign out_valid = state_q == DONE;
   assign out = out_q;
   assign invalid = invalid_q;
   assign inexact = inexact_q;
endmodule

// File: tb/tb_fp2int_conv.sv
// tb_fp2int_conv: directed vector table plus stall and mid-conversion reset sequences.
module tb_fp2int_conv;
   logic        clk = 1'b0, rst = 1'b1, in_valid = 1'b0, is_signed = 1'b0, out_ready = 1'b0;
   logic [31:0] in = 32'd0;
   logic        in_ready, out_valid, invalid, inexact;
   logic [31:0] out;
   int          n_cmp = 0, n_bad = 0;

   fp2int_conv dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in(in),
      .is_signed(is_signed), .out_valid(out_valid), .out_ready(out_ready), .out(out),
      .invalid(invalid), .inexact(inexact)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] f;
      logic        s;
      logic [31:0] q;
      logic        inv;
      logic        inx;
      int          lat;
   } vec_t;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
      n_cmp++;
      if (act !== exp_v) begin
         n_bad++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp_v);
      end
   endtask

   // start a conversion at a negedge; returns edges counted from the accepting edge to out_valid
   task automatic launch(input logic [31:0] f, input logic s, output int lat);
      in = f;
      is_signed = s;
      in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      lat = 1;
      chk("busy_in_ready", {31'd0, in_ready}, 32'd0);
      while (!out_valid && lat < 60) begin
         @(negedge clk);
         lat++;
      end
   endtask

   task automatic drain();
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      chk("drain_out_valid", {31'd0, out_valid}, 32'd0);
      chk("drain_in_ready", {31'd0, in_ready}, 32'd1);
   endtask

   vec_t vt[$];
   initial begin
      int lat;
      logic [31:0] held;
      vt = '{
         '{32'h3FC00000, 1'b1, 32'd2,          1'b0, 1'b1, 25},
         '{32'h40200000, 1'b1, 32'd2,          1'b0, 1'b1, 24},
         '{32'hC0600000, 1'b1, 32'hFFFFFFFC,   1'b0, 1'b1, 24},
         '{32'hCF000000, 1'b1, 32'h80000000,   1'b0, 1'b0, 10},
         '{32'h4F000000, 1'b1, 32'h7FFFFFFF,   1'b1, 1'b0, 2},
         '{32'h4F000000, 1'b0, 32'h80000000,   1'b0, 1'b0, 10},
         '{32'h4F800000, 1'b0, 32'hFFFFFFFF,   1'b1, 1'b0, 2},
         '{32'h7FC00000, 1'b1, 32'h7FFFFFFF,   1'b1, 1'b0, 2},
         '{32'hBF800000, 1'b0, 32'd0,          1'b1, 1'b0, 25},
         '{32'hBE99999A, 1'b0, 32'd0,          1'b0, 1'b1, 2},
         '{32'h00000001, 1'b1, 32'd0,          1'b0, 1'b1, 2},
         '{32'h3F000000, 1'b1, 32'd0,          1'b0, 1'b1, 2},
         '{32'h3F400000, 1'b1, 32'd1,          1'b0, 1'b1, 2},
         '{32'h80000000, 1'b0, 32'd0,          1'b0, 1'b0, 2},
         '{32'hFF800000, 1'b1, 32'h80000000,   1'b1, 1'b0, 2},
         '{32'h3FC00000, 1'b0, 32'd2,          1'b0, 1'b1, 25},
         '{32'hC0600000, 1'b0, 32'd0,          1'b1, 1'b0, 24},
         '{32'h4F7FFFFF, 1'b1, 32'h7FFFFFFF,   1'b1, 1'b0, 2}
      };
      repeat (2) @(negedge clk);
      chk("reset_in_ready", {31'd0, in_ready}, 32'd1);
      chk("reset_out_valid", {31'd0, out_valid}, 32'd0);
      chk("reset_out", out, 32'd0);
      chk("reset_flags", {30'd0, invalid, inexact}, 32'd0);
      rst = 1'b0;
      @(negedge clk);
      foreach (vt[i]) begin
         launch(vt[i].f, vt[i].s, lat);
         chk($sformatf("v%0d_latency", i), lat, vt[i].lat);
         chk($sformatf("v%0d_out", i), out, vt[i].q);
         chk($sformatf("v%0d_invalid", i), {31'd0, invalid}, {31'd0, vt[i].inv});
         chk($sformatf("v%0d_inexact", i), {31'd0, inexact}, {31'd0, vt[i].inx});
         drain();
      end
      // held result under back-pressure, with a stray in_valid that must be ignored
      launch(32'h4B000001, 1'b1, lat);
      chk("stall_latency", lat, 2);
      held = 32'd8388609;
      in = 32'h40000000;
      in_valid = 1'b1;
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         chk("stall_out", out, held);
         chk("stall_valid", {31'd0, out_valid}, 32'd1);
         chk("stall_in_ready", {31'd0, in_ready}, 32'd0);
      end
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      in_valid = 1'b0;
      chk("leave_done_no_accept", {31'd0, in_ready}, 32'd1);
      chk("leave_done_valid", {31'd0, out_valid}, 32'd0);
      // reset in the third SHIFT cycle of 1.0
      in = 32'h3F800000;
      is_signed = 1'b1;
      in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("midrst_out_valid", {31'd0, out_valid}, 32'd0);
      chk("midrst_in_ready", {31'd0, in_ready}, 32'd1);
      chk("midrst_out", out, 32'd0);
      begin
         int seen = 0;
         repeat (30) begin
            @(negedge clk);
            if (out_valid) seen = 1;
         end
         chk("midrst_discarded", seen, 0);
      end
      launch(32'h41200000, 1'b1, lat);
      chk("ten_latency", lat, 22);
      chk("ten_out", out, 32'd10);
      chk("ten_flags", {30'd0, invalid, inexact}, 32'd0);
      drain();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
